lsu_dmem_align: RTL and testbench

- Load/store access controller between the execute/memory pipeline stage and data memory.
- Directly upstream of the load extender: delivers loaded data right-aligned and zero-padded to the requested width; the extender then sign- or zero-extends it.
- Generates word-aligned memory requests with byte enables and lane-replicated store data.
- Runs a request/ack handshake with the memory and flags misaligned accesses without touching memory.

---
 rtl/lsu_dmem_align.sv | 199 +++++++++++++++++++
 tb/tb_lsu_dmem_align.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_align.sv
// lsu_dmem_align: load/store access controller between the memory pipeline
// stage and data memory. It issues word-aligned requests with byte enables
// and lane-replicated store data, and handshakes with the memory
// (mem_req/mem_ack). It returns load data right-aligned and zero-padded,
// ready for the load extender. Misaligned accesses and the reserved mode
// are answered with rsp_err and never reach memory.
//
// Ports
//   clk, rst          : clock (rising edge), async active-high reset
//   req_valid/ready   : access request handshake (ready only while idle)
//   req_we            : 1 = store, 0 = load
//   req_accessmode    : 00 byte, 01 half, 10 word, 11 reserved
//   req_addr          : byte address
//   req_wdata         : store data, right-aligned
//   rsp_valid         : one-cycle completion pulse
//   rsp_err           : misaligned/reserved access, valid with rsp_valid
//   rsp_rdata         : aligned load data (zero for stores and errors)
//   mem_req/we/addr   : memory request, write flag, word address
//   mem_be, mem_wdata : byte enables, lane-replicated store data
//   mem_ack, mem_rdata: memory completion and read word (same cycle)
module lsu_dmem_align #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_accessmode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]            state_r;
  // Set for the single cycle after acceptance, while the latched request is
  // classified; this is what places mem_req one edge after the accept edge.
  logic                  pend_r;
  logic                  lat_we_r;
  logic [1:0]            lat_mode_r;
  logic [ADDR_WIDTH-1:0] lat_addr_r;
  logic [31:0]           lat_wdata_r;

  logic [1:0]            off_s;
  logic                  err_s;

  // Reserved mode, odd half-word offsets and non-zero word offsets are illegal.
  function automatic logic calc_err(input logic [1:0] mode, input logic [1:0] off);
    logic r;
    case (mode)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      2'b10:   r = (off != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] calc_be(input logic [1:0] mode, input logic [1:0] off);
    logic [3:0] r;
    case (mode)
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = 4'b0011 << off;
      2'b10:   r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Replicate the store data across lanes so the byte enables pick the lane.
  function automatic logic [31:0] calc_wdata(input logic [1:0] mode, input logic [31:0] w);
    logic [31:0] r;
    case (mode)
      2'b00:   r = {4{w[7:0]}};
      2'b01:   r = {2{w[15:0]}};
      2'b10:   r = w;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Shift the addressed lane down to bit 0 and clear everything above it.
  function automatic logic [31:0] calc_rdata(input logic [1:0] mode, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [31:0] tmp;
    logic [31:0] r;
    tmp = rd >> {off, 3'b000};
    case (mode)
      2'b00:   r = {24'h00_0000, tmp[7:0]};
      2'b01:   r = {16'h0000, tmp[15:0]};
      2'b10:   r = tmp;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign off_s = lat_addr_r[1:0];
  assign err_s = calc_err(lat_mode_r, off_s);

  // Access FSM; every output is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pend_r      <= 1'b0;
      lat_we_r    <= 1'b0;
      lat_mode_r  <= 2'b00;
      lat_addr_r  <= {ADDR_WIDTH{1'b0}};
      lat_wdata_r <= 32'h0000_0000;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'h0000_0000;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {ADDR_WIDTH{1'b0}};
      mem_be      <= 4'b0000;
      mem_wdata   <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pend_r) begin
            pend_r <= 1'b0;
            if (err_s) begin
              state_r   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0000_0000;
            end else begin
              state_r   <= ST_ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= lat_we_r;
              mem_addr  <= {lat_addr_r[ADDR_WIDTH-1:2], 2'b00};
              mem_be    <= calc_be(lat_mode_r, off_s);
              mem_wdata <= calc_wdata(lat_mode_r, lat_wdata_r);
            end
          end else if (req_valid) begin
            pend_r      <= 1'b1;
            req_ready   <= 1'b0;
            lat_we_r    <= req_we;
            lat_mode_r  <= req_accessmode;
            lat_addr_r  <= req_addr;
            lat_wdata_r <= req_wdata;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state_r   <= ST_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_WIDTH{1'b0}};
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0000_0000;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= lat_we_r ? 32'h0000_0000 : calc_rdata(lat_mode_r, off_s, mem_rdata);
          end else begin
            state_r <= ST_ACCESS;
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0000_0000;
          req_ready <= 1'b1;
        end
        default: begin
          state_r   <= ST_IDLE;
          pend_r    <= 1'b0;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0000_0000;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= {ADDR_WIDTH{1'b0}};
          mem_be    <= 4'b0000;
          mem_wdata <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_align.sv
// Testbench for lsu_dmem_align: directed and randomized accesses checked
// against a byte-lane reference model.
module tb_lsu_dmem_align;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_accessmode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_dmem_align #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_accessmode(req_accessmode), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: access size in bytes, lane by lane.
  function automatic int size_of(input logic [1:0] mode);
    return 1 << mode;
  endfunction

  function automatic bit ref_err(input logic [1:0] mode, input logic [31:0] addr);
    if (mode == 2'b11) return 1'b1;
    return (addr % size_of(mode)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] mode, input logic [31:0] addr);
    logic [3:0] be;
    int off;
    off = addr % 4;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + size_of(mode));
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] mode, input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % size_of(mode)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rdata(input logic we, input logic [1:0] mode,
                                            input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] r;
    int off;
    r = 32'h0;
    off = addr % 4;
    if (we || ref_err(mode, addr)) return r;
    for (int i = 0; i < size_of(mode); i++) r[8*i +: 8] = rd[8*(off + i) +: 8];
    return r;
  endfunction

  // Runs one access starting at a negedge and returns what was observed.
  // Ends at the negedge where the block is idle again.
  task automatic do_access(input logic we, input logic [1:0] mode, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int waits, input bit noise,
                           output logic [3:0] o_be, output logic [31:0] o_addr,
                           output logic [31:0] o_wdata, output logic o_we,
                           output logic o_err, output logic [31:0] o_rdata, output int o_lat);
    bit          e_err;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd, e_rd;
    int          e_lat, k, acc, rsp_cnt;
    bit          finished;
    e_err  = ref_err(mode, addr);
    e_be   = ref_be(mode, addr);
    e_addr = addr & 32'hFFFF_FFFC;
    e_wd   = ref_wdata(mode, wdata);
    e_rd   = ref_rdata(we, mode, addr, rdata);
    e_lat  = e_err ? 1 : 2 + waits;
    o_be = 4'b0; o_addr = 32'h0; o_wdata = 32'h0; o_we = 1'b0;
    o_err = 1'b0; o_rdata = 32'h0; o_lat = -1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_at_start got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_accessmode = mode; req_addr = addr; req_wdata = wdata;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0; acc = 0; rsp_cnt = 0; finished = 0;
    while (!finished && k < waits + 12) begin
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom; req_valid = 1'b0;
      if (mem_req === 1'b1) begin
        checks++;
        if (e_err || rsp_cnt > 0 || req_ready !== 1'b0 || mem_we !== we || mem_addr !== e_addr ||
            mem_be !== e_be || (we && mem_wdata !== e_wd)) begin
          errors++;
          $display("FAIL mem_request got we=%b addr=%h be=%b wd=%h rdy=%b want we=%b addr=%h be=%b wd=%h rdy=0 err=%b",
                   mem_we, mem_addr, mem_be, mem_wdata, req_ready, we, e_addr, e_be, e_wd, e_err);
        end
        o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
        acc++;
        if (acc == waits + 1) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else if (noise) begin
          req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom;
        end
      end else if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        o_err = rsp_err; o_rdata = rsp_rdata; o_lat = k;
        checks++;
        if (rsp_err !== e_err || rsp_rdata !== e_rd || k != e_lat || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL response got err=%b rdata=%h lat=%0d rdy=%b want err=%b rdata=%h lat=%0d rdy=0",
                   rsp_err, rsp_rdata, k, req_ready, e_err, e_rd, e_lat);
        end
        if (noise) mem_ack = 1'b1;
      end else if (rsp_cnt > 0) begin
        finished = 1;
        checks++;
        if (req_ready !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
          errors++;
          $display("FAIL after_resp got rdy=%b err=%b rdata=%h want 1 0 0", req_ready, rsp_err, rsp_rdata);
        end
      end else begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL busy_ready got %b want 0", req_ready);
        end
        if (noise && acc == 0) mem_ack = 1'($urandom_range(0, 1));
      end
      k++;
    end
    checks++;
    if (!finished || rsp_cnt != 1) begin
      errors++; $display("FAIL completion got finished=%0d responses=%0d want 1 1", finished, rsp_cnt);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_accessmode = 2'b00;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
        mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 ||
        mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b rv=%b re=%b rd=%h mr=%b mw=%b ma=%h be=%b wd=%h want all 0, rdy=1",
               req_ready, rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_byte_load;
    logic [3:0] be; logic [31:0] a, wd, rd; logic we, er; int lat;
    do_access(1'b0, 2'b00, 32'h103, 32'h0, 32'hAB00_0000, 0, 1'b0, be, a, wd, we, er, rd, lat);
    checks++;
    if (be !== 4'b1000 || a !== 32'h100 || rd !== 32'h0000_00AB || lat != 2 || er !== 1'b0) begin
      errors++;
      $display("FAIL byte_load got be=%b addr=%h rdata=%h lat=%0d err=%b want 1000 100 000000ab 2 0",
               be, a, rd, lat, er);
    end
  endtask

  task automatic test_half_store;
    logic [3:0] be; logic [31:0] a, wd, rd; logic we, er; int lat;
    do_access(1'b1, 2'b01, 32'h202, 32'h1234_BEEF, 32'hDEAD_0000, 1, 1'b0, be, a, wd, we, er, rd, lat);
    checks++;
    if (be !== 4'b1100 || wd !== 32'hBEEF_BEEF || we !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL half_store got be=%b wd=%h we=%b err=%b rdata=%h want 1100 beefbeef 1 0 0",
               be, wd, we, er, rd);
    end
  endtask

  task automatic test_misaligned;
    logic [3:0] be; logic [31:0] a, wd, rd; logic we, er; int lat;
    logic [1:0]  modes [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] addrs [3] = '{32'h301, 32'h3, 32'h0};
    for (int i = 0; i < 3; i++) begin
      do_access(1'b0, modes[i], addrs[i], 32'h0, 32'hFFFF_FFFF, 0, 1'b1, be, a, wd, we, er, rd, lat);
      checks++;
      if (er !== 1'b1 || lat != 1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL misaligned_%0d got err=%b lat=%0d rdata=%h want 1 1 0", i, er, lat, rd);
      end
    end
  endtask

  task automatic test_wait_ack;
    logic [3:0] be; logic [31:0] a, wd, rd, mrd; logic we, er; int lat;
    mrd = $urandom;
    do_access(1'b0, 2'b10, 32'h500, 32'h0, mrd, 4, 1'b1, be, a, wd, we, er, rd, lat);
    checks++;
    if (lat != 6 || rd !== mrd || be !== 4'b1111) begin
      errors++;
      $display("FAIL wait_ack got lat=%0d rdata=%h be=%b want 6 %h 1111", lat, rd, be, mrd);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] be; logic [31:0] a, wd, rd; logic we, er; int lat;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] m;
      m = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_access(1'($urandom_range(0, 1)), m, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), 1'b1, be, a, wd, we, er, rd, lat);
    end
  endtask

  task automatic test_reset_mid_access;
    int k;
    req_valid = 1'b1; req_we = 1'b0; req_accessmode = 2'b10; req_addr = 32'h400;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (mem_req !== 1'b1 && k < 5) begin
      @(negedge clk); k++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL reset_setup got mem_req=%b want 1", mem_req);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_be !== 4'h0) begin
      errors++;
      $display("FAIL async_reset got mem_req=%b rdy=%b rv=%b be=%b want 0 1 0 0",
               mem_req, req_ready, rsp_valid, mem_be);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL late_ack_%0d got rv=%b mem_req=%b rdy=%b want 0 0 1", i, rsp_valid, mem_req, req_ready);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_wait_ack();
    test_back_to_back();
    test_reset_mid_access();
    test_byte_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
